// File: rtl/ss_scan_sched_if.sv
// Purpose: message-overlay request/acknowledge bundle between a message producer and ss_scan_sched.
// Latency: none, wires only.
// Backpressure: producer holds msg_req and msg_data stable until msg_ack pulses.
// Ports:
//   msg_req   producer -> scheduler, request pending
//   msg_data  producer -> scheduler, 8 nibbles, [3:0] = digit 0
//   msg_ack   scheduler -> producer, one-cycle capture pulse
interface ss_scan_sched_if;
    logic        msg_req;
    logic [31:0] msg_data;
    logic        msg_ack;

    modport master (
        output msg_req,
        output msg_data,
        input  msg_ack
    );

    modport slave (
        input  msg_req,
        input  msg_data,
        output msg_ack
    );
endinterface

// File: rtl/ss_scan_sched.sv
// Purpose: scan scheduler for the 8-digit seven-segment display with PWM, lz blanking and message overlay.
// Latency: sel/value/AN/src/frame_tick/msg_ack are registered, one cycle after the counters they reflect.
// Backpressure: msg_req waits for the next frame boundary; msg_ack pulses once per captured message.
// Ports:
//   CLK100MHZ  system clock            rst        synchronous reset, active-low
//   score_data live score, 8 BCD digits lz_blank   blank leading zeros of the score
//   msg        message req/data/ack    digit_en   per-digit enable mask
//   bright     PWM level, 0..15        sel/value  current digit index and nibble
//   AN         active-low anodes       src        1 = message shown
//   frame_tick one pulse per frame
module ss_scan_sched #(
    parameter int SUB_DIV     = 781,
    parameter int HOLD_FRAMES = 500
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic [31:0]         score_data,
    input  logic                lz_blank,
    ss_scan_sched_if.slave      msg,
    input  logic [7:0]          digit_en,
    input  logic [3:0]          bright,
    output logic [2:0]          sel,
    output logic [3:0]          value,
    output logic [7:0]          AN,
    output logic                src,
    output logic                frame_tick
);

    localparam int PRE_W  = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SUB_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic {
        ST_SCORE = 1'b0,
        ST_MSG   = 1'b1
    } state_t;

    // Everything the display side sees is launched from one register so the
    // digit index, nibble and anode pattern can never disagree.
    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] value;
        logic [7:0] an;
        logic       src;
        logic       tick;
        logic       ack;
    } disp_t;

    localparam disp_t DISP_RST = '{sel: 3'd0, value: 4'd0, an: 8'hFF,
                                   src: 1'b0, tick: 1'b0, ack: 1'b0};

    // ------------------------------------------------------------------
    // Scan counters: pre (clock divider) -> sub (PWM slot) -> dig (digit)
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre;
    logic [3:0]       sub;
    logic [2:0]       dig;
    logic             first_q;   // first cycle after reset counts as a frame boundary

    logic pre_wrap;
    logic sub_wrap;
    logic boundary;

    assign pre_wrap = (pre == PRE_LAST);
    assign sub_wrap = pre_wrap && (sub == 4'hF);
    assign boundary = first_q || (sub_wrap && (dig == 3'd7));

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            pre     <= '0;
            sub     <= 4'd0;
            dig     <= 3'd0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            pre     <= pre_wrap ? '0 : pre + PRE_W'(1);
            if (pre_wrap) begin
                sub <= sub + 4'd1;
            end
            if (sub_wrap) begin
                dig <= dig + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Score shadow: only refreshed at frame boundaries so a frame never
    // mixes digits from two different score values.
    // ------------------------------------------------------------------
    logic [31:0] score_sh;

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            score_sh <= 32'd0;
        end else if (boundary) begin
            score_sh <= score_data;
        end
    end

    // ------------------------------------------------------------------
    // Overlay FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic [31:0]       msg_sh;
    logic              take;

    // A request is only ever taken at a boundary, in either state; in MSG
    // this is a preempt that replaces the message and restarts the hold.
    assign take = boundary && msg.msg_req;

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            state  <= ST_SCORE;
            hold   <= '0;
            msg_sh <= 32'd0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            if (take) begin
                msg_sh <= msg.msg_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        case (state)
            ST_SCORE: begin
                if (take) begin
                    state_nxt = ST_MSG;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            ST_MSG: begin
                if (take) begin
                    hold_nxt = HOLD_LOAD;
                end else if (boundary) begin
                    // hold counts the frames still owed after the current one
                    if (hold == '0) begin
                        state_nxt = ST_SCORE;
                    end else begin
                        hold_nxt = hold - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_SCORE;
                hold_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit content, blanking and PWM gate
    // ------------------------------------------------------------------
    logic [31:0] shown;
    logic [7:0]  upper_zero;   // bit n: nibbles n..7 of the score shadow are all zero
    logic        blank;
    logic        lit;
    disp_t       disp_nxt;
    disp_t       disp_q;

    always_comb begin
        upper_zero    = 8'd0;
        upper_zero[7] = (score_sh[31:28] == 4'h0);
        for (int n = 6; n >= 0; n--) begin
            upper_zero[n] = upper_zero[n+1] && (score_sh[4*n +: 4] == 4'h0);
        end
    end

    always_comb begin
        shown = (state == ST_MSG) ? msg_sh : score_sh;

        // digit 0 is never blanked so a zero score still shows "0"
        blank = (state == ST_SCORE) && lz_blank && (dig != 3'd0) && upper_zero[dig];

        // bright=N lights sub-slots 0..N, giving (N+1)/16 duty
        lit = (sub <= bright) && digit_en[dig] && !blank;

        disp_nxt       = DISP_RST;
        disp_nxt.sel   = dig;
        disp_nxt.value = shown[{dig, 2'b00} +: 4];
        disp_nxt.an    = lit ? ~(8'h01 << dig) : 8'hFF;
        disp_nxt.src   = (state == ST_MSG);
        disp_nxt.tick  = boundary;
        disp_nxt.ack   = take;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            disp_q <= DISP_RST;
        end else begin
            disp_q <= disp_nxt;
        end
    end

    assign sel         = disp_q.sel;
    assign value       = disp_q.value;
    assign AN          = disp_q.an;
    assign src         = disp_q.src;
    assign frame_tick  = disp_q.tick;
    assign msg.msg_ack = disp_q.ack;

endmodule

// File: tb/tb_ss_scan_sched.sv
// Purpose: self-checking bench for ss_scan_sched against a cycle-count based reference model.
// Latency: model predicts the registered outputs one clock after the inputs it sees.
// Backpressure: bench requester holds msg_req/msg_data until the model predicts the ack.
module tb_ss_scan_sched;

    localparam int SD     = 2;
    localparam int HOLD   = 3;
    localparam int PERIOD = SD * 16 * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] score_data;
    logic        lz_blank;
    logic [7:0]  digit_en;
    logic [3:0]  bright;
    logic        req;
    logic [31:0] mdata;
    logic [2:0]  sel;
    logic [3:0]  value;
    logic [7:0]  AN;
    logic        src;
    logic        frame_tick;

    ss_scan_sched_if mif ();
    assign mif.msg_req  = req;
    assign mif.msg_data = mdata;

    ss_scan_sched #(.SUB_DIV(SD), .HOLD_FRAMES(HOLD)) dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .score_data (score_data),
        .lz_blank   (lz_blank),
        .msg        (mif),
        .digit_en   (digit_en),
        .bright     (bright),
        .sel        (sel),
        .value      (value),
        .AN         (AN),
        .src        (src),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // reference model state
    int          c;            // cycles since reset release
    bit          active;       // message overlay on
    int          frames_left;  // boundaries remaining before overlay ends
    logic [31:0] ssh;
    logic [31:0] msh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic [2:0]  e_sel;
        logic [3:0]  e_val;
        logic [7:0]  e_an;
        logic        e_src, e_ack, e_tick;
        logic [31:0] shown;
        int          dig, sub;
        bit          bnd, blank, lit;
        if (!rst) begin
            e_sel = 3'd0; e_val = 4'd0; e_an = 8'hFF;
            e_src = 1'b0; e_ack = 1'b0; e_tick = 1'b0;
            c = 0; active = 0; frames_left = 0; ssh = 32'd0; msh = 32'd0;
        end else begin
            dig   = (c / (SD * 16)) % 8;
            sub   = (c / SD) % 16;
            bnd   = (c == 0) || (c % PERIOD == PERIOD - 1);
            shown = active ? msh : ssh;
            e_sel = 3'(dig);
            e_val = 4'((shown >> (4 * dig)) & 32'hF);
            e_src = active;
            blank = !active && lz_blank && (dig > 0) && ((ssh >> (4 * dig)) == 32'd0);
            lit   = (sub <= int'(bright)) && digit_en[dig] && !blank;
            e_an  = lit ? ~(8'h01 << dig) : 8'hFF;
            e_tick = bnd;
            e_ack  = bnd && req;
            if (bnd) begin
                ssh = score_data;
                if (req) begin
                    msh = mdata;
                    active = 1;
                    frames_left = HOLD;
                end else if (active) begin
                    frames_left--;
                    if (frames_left == 0) active = 0;
                end
            end
            c++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("sel", 32'(sel), 32'(e_sel));
        chk("value", 32'(value), 32'(e_val));
        chk("AN", 32'(AN), 32'(e_an));
        chk("src", 32'(src), 32'(e_src));
        chk("msg_ack", 32'(mif.msg_ack), 32'(e_ack));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        if (e_ack) req = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic request(input logic [31:0] d);
        mdata = d;
        req   = 1'b1;
    endtask

    initial begin
        rst = 1'b0; score_data = 32'd0; lz_blank = 1'b0; digit_en = 8'hFF;
        bright = 4'hF; req = 1'b0; mdata = 32'd0;
        #2;
        // reset held for 3 clocks, then release
        run(3);
        rst = 1'b1;
        score_data = 32'h76543210;
        run(600);

        // PWM levels and digit mask
        bright = 4'd3;  run(300);
        bright = 4'd0;  run(300);
        bright = 4'hF; digit_en = 8'h0F; run(300);
        digit_en = 8'hFF;

        // leading-zero blanking
        lz_blank = 1'b1; score_data = 32'h00000120; run(300);
        score_data = 32'h00000000; run(300);
        lz_blank = 1'b0; score_data = 32'h76543210;

        // overlay requested mid-frame
        run(100);
        request(32'hEEEEEEEE);
        run(1100);

        // preempt during overlay, then reset mid-overlay
        request(32'hABCDEF01);
        run(450);
        request(32'h13572468);
        run(500);
        rst = 1'b0; run(2);
        rst = 1'b1; run(50);

        // randomized operation
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) score_data = $urandom;
            if ($urandom_range(0, 149) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 399) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 499) == 0) begin
                score_data = 32'($urandom_range(0, 4095));
                lz_blank = 1'b1;
            end
            if (!req && $urandom_range(0, 299) == 0) request($urandom);
            if ($urandom_range(0, 1999) == 0) rst = 1'b0;
            else rst = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
